// File: rtl/mic_pkg.sv
// Shared types and constants for the I2S microphone capture front end.
package mic_pkg;

  localparam int NUM_MICS_DEF = 5;
  localparam int SAMPLE_W     = 24;
  localparam int SLOT_BITS    = 32;
  localparam int FRAME_BITS   = 64;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } cap_state_t;

  typedef logic [31:0] sample_t;

  // Sign-extend a 24-bit two's complement sample to the 32-bit bus word.
  function automatic sample_t sext_sample(input logic [SAMPLE_W-1:0] s);
    return {{(32-SAMPLE_W){s[SAMPLE_W-1]}}, s};
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// I2S bit clock / word select generator. The divider and bit counter
// run only while `run` is high and are held cleared otherwise, so the
// first SCK rise after starting always carries bit 0 of the left slot.
module i2s_clkgen
  import mic_pkg::*;
#(
  parameter int SCK_DIV = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       run,
  output logic       mic_sck,
  output logic       mic_ws,
  output logic       sck_rise,
  output logic       sck_fall,
  output logic [5:0] bit_cnt
);

  localparam logic [7:0] DIV_LAST = 8'(SCK_DIV - 1);

  logic [7:0] div_cnt_q;
  logic       sck_q;
  logic       ws_q;
  logic [5:0] bit_cnt_q;
  logic [5:0] bit_cnt_d;
  logic       tick_s;

  assign tick_s    = run && (div_cnt_q == DIV_LAST);
  assign sck_rise  = tick_s && !sck_q;
  assign sck_fall  = tick_s && sck_q;
  assign bit_cnt_d = bit_cnt_q + 6'd1;

  assign mic_sck = sck_q;
  assign mic_ws  = ws_q;
  assign bit_cnt = bit_cnt_q;

  // Divider, SCK toggle, and bit counter / WS update on SCK falling edges.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      div_cnt_q <= 8'd0;
      sck_q     <= 1'b0;
      ws_q      <= 1'b0;
      bit_cnt_q <= 6'd0;
    end else if (!run) begin
      div_cnt_q <= 8'd0;
      sck_q     <= 1'b0;
      ws_q      <= 1'b0;
      bit_cnt_q <= 6'd0;
    end else begin
      div_cnt_q <= tick_s ? 8'd0 : (div_cnt_q + 8'd1);
      if (tick_s) begin
        sck_q <= !sck_q;
      end
      if (sck_fall) begin
        bit_cnt_q <= bit_cnt_d;
        // Right slot is the upper half of the 64-bit frame.
        ws_q      <= bit_cnt_d[5];
      end
    end
  end

endmodule

// File: rtl/i2s_mic_capture.sv
// Multi-microphone I2S capture: synchronises the serial lines, shifts in
// the 24-bit left-slot sample of each mic, and latches a full frame into
// a holding bank read by the DMA through a select-indexed mux.
module i2s_mic_capture
  import mic_pkg::*;
#(
  parameter int NUM_MICS = NUM_MICS_DEF,
  parameter int SCK_DIV  = 8
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                enable,
  input  logic [NUM_MICS-1:0] mic_sd,
  output logic                mic_sck,
  output logic                mic_ws,
  input  logic [2:0]          select,
  output logic [31:0]         mic_data,
  input  logic                frame_ack,
  output logic                read_ready,
  output logic [15:0]         overrun_count
);

  cap_state_t state_q;
  cap_state_t state_d;
  logic       run_s;
  logic       sck_rise_s;
  logic       sck_fall_s;
  logic       unused_s;
  logic [5:0] bit_cnt_s;

  logic [NUM_MICS-1:0] sd_meta_q;
  logic [NUM_MICS-1:0] sd_sync_q;
  logic [SAMPLE_W-1:0] shift_q [NUM_MICS];
  logic [SAMPLE_W-1:0] shift_d [NUM_MICS];
  sample_t             bank_q  [NUM_MICS];
  logic                read_ready_q;
  logic [15:0]         overrun_q;
  logic [31:0]         mic_data_s;

  logic shift_en_s;
  logic frame_end_s;
  logic latch_s;
  logic drop_s;

  // Next-state for the IDLE/RUN capture state.
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = enable ? RUN : IDLE;
      RUN:     state_d = enable ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture state register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Dropping enable stops the interface on the very next edge.
  assign run_s = (state_q == RUN) && enable;

  i2s_clkgen #(
    .SCK_DIV(SCK_DIV)
  ) u_clkgen (
    .CLK      (CLK),
    .RESET    (RESET),
    .run      (run_s),
    .mic_sck  (mic_sck),
    .mic_ws   (mic_ws),
    .sck_rise (sck_rise_s),
    .sck_fall (sck_fall_s),
    .bit_cnt  (bit_cnt_s)
  );

  // Falling-edge strobe is not needed here; data is sampled on rises.
  assign unused_s = sck_fall_s;

  assign shift_en_s  = sck_rise_s && (bit_cnt_s != 6'd0) && (bit_cnt_s <= 6'd24);
  assign frame_end_s = sck_rise_s && (bit_cnt_s == 6'd24);
  assign latch_s     = frame_end_s && (!read_ready_q || frame_ack);
  assign drop_s      = frame_end_s && read_ready_q && !frame_ack;

  // Two-flop synchroniser for the asynchronous mic data lines.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sd_meta_q <= '0;
      sd_sync_q <= '0;
    end else begin
      sd_meta_q <= mic_sd;
      sd_sync_q <= sd_meta_q;
    end
  end

  // MSB-first shift of the synchronised bit; latch uses this value so the
  // 24th data bit is included in the same cycle.
  always_comb begin
    for (int i = 0; i < NUM_MICS; i++) begin
      shift_d[i] = shift_en_s ? {shift_q[i][SAMPLE_W-2:0], sd_sync_q[i]} : shift_q[i];
    end
  end

  // Per-mic shift registers, discarded whenever the interface is idle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NUM_MICS; i++) shift_q[i] <= '0;
    end else if (!run_s) begin
      for (int i = 0; i < NUM_MICS; i++) shift_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_MICS; i++) shift_q[i] <= shift_d[i];
    end
  end

  // Holding bank, updated only when a complete frame is accepted.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NUM_MICS; i++) bank_q[i] <= '0;
    end else if (latch_s) begin
      for (int i = 0; i < NUM_MICS; i++) bank_q[i] <= sext_sample(shift_d[i]);
    end else begin
      for (int i = 0; i < NUM_MICS; i++) bank_q[i] <= bank_q[i];
    end
  end

  // Read handshake and saturating overrun counter.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      read_ready_q <= 1'b0;
      overrun_q    <= 16'd0;
    end else begin
      if (latch_s) begin
        read_ready_q <= 1'b1;
      end else if (frame_ack) begin
        read_ready_q <= 1'b0;
      end else begin
        read_ready_q <= read_ready_q;
      end
      if (drop_s && (overrun_q != 16'hFFFF)) begin
        overrun_q <= overrun_q + 16'd1;
      end else begin
        overrun_q <= overrun_q;
      end
    end
  end

  // Select mux: select k (1-based) reads mic k, anything else reads zero.
  always_comb begin
    mic_data_s = 32'd0;
    for (int i = 0; i < NUM_MICS; i++) begin
      mic_data_s = mic_data_s | ((select == 3'(i + 1)) ? bank_q[i] : 32'd0);
    end
  end

  assign mic_data      = mic_data_s;
  assign read_ready    = read_ready_q;
  assign overrun_count = overrun_q;

endmodule

// File: tb/tb_i2s_mic_capture.sv
// Self-checking bench: random mic data from a bit-serial mic model,
// checked against a frame-level model of the bank/handshake behaviour.
module tb_i2s_mic_capture;

  localparam int NM    = 5;
  localparam int DIV   = 8;
  localparam int LAT   = 393;        // enable -> latch edge: 1 + 8 + 24*16
  localparam int FRAME = 128 * DIV;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          enable = 1'b0;
  logic          frame_ack = 1'b0;
  logic [NM-1:0] mic_sd = '0;
  logic [2:0]    select = 3'd0;
  logic          mic_sck;
  logic          mic_ws;
  logic [31:0]   mic_data;
  logic          read_ready;
  logic [15:0]   overrun_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t0 = 0;
  bit pattern_mode = 1'b1;

  logic [23:0] cur_frame [NM];
  logic [31:0] exp_bank  [NM];
  bit          exp_rr;
  int          exp_ovr;

  int sck_rises[$];
  int ws_rises[$];
  int ws_falls[$];

  i2s_mic_capture #(.NUM_MICS(NM), .SCK_DIV(DIV)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .enable        (enable),
    .mic_sd        (mic_sd),
    .mic_sck       (mic_sck),
    .mic_ws        (mic_ws),
    .select        (select),
    .mic_data      (mic_data),
    .frame_ack     (frame_ack),
    .read_ready    (read_ready),
    .overrun_count (overrun_count)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sx(input logic [23:0] v);
    int t;
    t = int'(v);
    if (t >= 32'h0080_0000) t = t - 32'h0100_0000;
    return 32'(t);
  endfunction

  // Mic model: after the j-th SCK falling edge the next rise samples slot bit j%64.
  initial begin
    int  fall_cnt;
    int  pos;
    bit  sp;
    fall_cnt = 0;
    sp = 1'b0;
    forever begin
      @(negedge CLK);
      if (RESET || !enable) begin
        fall_cnt = 0;
        sp = 1'b0;
      end else begin
        if (sp && !mic_sck) begin
          fall_cnt++;
          pos = fall_cnt % 64;
          if (pos == 1) begin
            for (int m = 0; m < NM; m++)
              cur_frame[m] = pattern_mode ? 24'(32'h0080_0001 * (m + 1)) : 24'($urandom);
          end
          if (pos >= 1 && pos <= 24) begin
            for (int m = 0; m < NM; m++) mic_sd[m] = cur_frame[m][24 - pos];
          end else begin
            mic_sd = NM'($urandom);
          end
        end
        sp = mic_sck;
      end
    end
  end

  // Timestamp SCK and WS edges of the first run.
  initial begin
    bit psck;
    bit pws;
    psck = 1'b0;
    pws = 1'b0;
    forever begin
      @(negedge CLK);
      if (mic_sck && !psck && sck_rises.size() < 4) sck_rises.push_back(cyc);
      if (mic_ws && !pws && ws_rises.size() < 2) ws_rises.push_back(cyc);
      if (!mic_ws && pws && ws_falls.size() < 2) ws_falls.push_back(cyc);
      psck = mic_sck;
      pws = mic_ws;
    end
  end

  task automatic run_to(input int c);
    while (cyc < c) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic model_frame_end(input bit ack);
    if (!exp_rr || ack) begin
      for (int m = 0; m < NM; m++) exp_bank[m] = sx(cur_frame[m]);
      exp_rr = 1'b1;
    end else if (exp_ovr < 65535) begin
      exp_ovr++;
    end
  endtask

  task automatic ack_pulse();
    frame_ack = 1'b1;
    run_to(cyc + 1);
    frame_ack = 1'b0;
    exp_rr = 1'b0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_rr"}, 32'(read_ready), 32'(exp_rr));
    chk({tag, "_ovr"}, 32'(overrun_count), 32'(exp_ovr));
    for (int s = 0; s < 8; s++) begin
      select = 3'(s);
      #1;
      chk($sformatf("%s_sel%0d", tag, s), mic_data,
          (s >= 1 && s <= NM) ? exp_bank[s - 1] : 32'd0);
    end
  endtask

  initial begin
    exp_rr = 1'b0;
    exp_ovr = 0;
    for (int m = 0; m < NM; m++) begin
      exp_bank[m] = 32'd0;
      cur_frame[m] = 24'd0;
    end

    run_to(4);
    RESET = 1'b0;
    run_to(6);
    check_state("reset");
    chk("reset_sck", 32'(mic_sck), 32'd0);
    chk("reset_ws", 32'(mic_ws), 32'd0);

    // First frame carries the fixed pattern 24'h800001*k.
    t0 = cyc;
    enable = 1'b1;
    run_to(t0 + LAT - 13);
    chk("rr_early", 32'(read_ready), 32'd0);
    run_to(t0 + LAT);
    model_frame_end(1'b0);
    run_to(t0 + LAT + 17);
    check_state("frame1");
    chk("frame1_mic1", exp_bank[0], 32'hFF80_0001);
    pattern_mode = 1'b0;

    // Two more frames without acknowledge: both dropped.
    run_to(t0 + LAT + FRAME);
    model_frame_end(1'b0);
    run_to(t0 + LAT + 2 * FRAME);
    model_frame_end(1'b0);
    run_to(t0 + LAT + 2 * FRAME + 20);
    check_state("overrun");
    chk("overrun_two", 32'(overrun_count), 32'd2);

    run_to(t0 + LAT + 2 * FRAME + 100);
    ack_pulse();
    run_to(cyc + 3);
    chk("ack_clears", 32'(read_ready), 32'(exp_rr));

    // SCK / WS timing from the first run.
    if (sck_rises.size() >= 3) begin
      chk("sck_first", ((sck_rises[0] - t0) <= 2 * DIV) ? 32'd1 : 32'd0, 32'd1);
      chk("sck_period0", 32'(sck_rises[1] - sck_rises[0]), 32'(2 * DIV));
      chk("sck_period1", 32'(sck_rises[2] - sck_rises[1]), 32'(2 * DIV));
    end else begin
      chk("sck_log", 32'(sck_rises.size()), 32'd3);
    end
    if (ws_rises.size() >= 2 && ws_falls.size() >= 1) begin
      chk("ws_high", 32'(ws_falls[0] - ws_rises[0]), 32'(32 * 2 * DIV));
      chk("ws_low", 32'(ws_rises[1] - ws_falls[0]), 32'(32 * 2 * DIV));
    end else begin
      chk("ws_log", 32'(ws_rises.size() + ws_falls.size()), 32'd3);
    end

    // Next frame after acknowledge latches.
    run_to(t0 + LAT + 3 * FRAME);
    model_frame_end(1'b0);
    run_to(t0 + LAT + 3 * FRAME + 17);
    check_state("after_ack");

    // Acknowledge in the very cycle of the latch.
    run_to(t0 + LAT + 4 * FRAME - 2);
    chk("pre_same_rr", 32'(read_ready), 32'(exp_rr));
    run_to(t0 + LAT + 4 * FRAME - 1);
    frame_ack = 1'b1;
    run_to(t0 + LAT + 4 * FRAME);
    frame_ack = 1'b0;
    model_frame_end(1'b1);
    run_to(cyc + 1);
    chk("same_rr_hold", 32'(read_ready), 32'd1);
    run_to(t0 + LAT + 4 * FRAME + 17);
    check_state("ack_same");

    run_to(t0 + LAT + 4 * FRAME + 100);
    ack_pulse();

    // Drop enable around bit 12 of the next frame.
    run_to(t0 + 5 * FRAME + 200);
    enable = 1'b0;
    run_to(cyc + 5);
    chk("idle_sck", 32'(mic_sck), 32'd0);
    chk("idle_ws", 32'(mic_ws), 32'd0);
    run_to(cyc + 100);
    check_state("disabled");

    t0 = cyc;
    enable = 1'b1;
    run_to(t0 + 300);
    check_state("no_partial");
    run_to(t0 + LAT);
    model_frame_end(1'b0);
    run_to(t0 + LAT + 17);
    check_state("restart");

    // Asynchronous reset mid-frame with a frame pending.
    select = 3'd1;
    run_to(t0 + 600);
    #2;
    RESET = 1'b1;
    #1;
    chk("arst_rr", 32'(read_ready), 32'd0);
    chk("arst_ovr", 32'(overrun_count), 32'd0);
    chk("arst_data", mic_data, 32'd0);
    chk("arst_sck", 32'(mic_sck), 32'd0);
    chk("arst_ws", 32'(mic_ws), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2s_mic_capture.md
# i2s_mic_capture

Front-end capture stage for the microphone array: generates the shared I2S bit clock and word select, deserialises one 24-bit left-slot sample per frame from each of NUM_MICS MEMS microphones, and latches them as one holding bank. The bank is presented to the downstream mic DMA through a `select`-indexed 32-bit mux with a `read_ready` flag. It sits between the board microphone pins and the DMA master that writes samples to SDRAM.

## Interface

Parameters:
- NUM_MICS, 5, number of microphones, one serial data line each, left slot only.
- SCK_DIV, 8, CLK cycles per SCK half period; legal range 4..255. At 50 MHz: SCK 3.125 MHz, fs 48.83 kHz.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- enable  in  1  run capture; low holds the I2S interface idle.
- mic_sd  in  NUM_MICS  serial data from each mic; asynchronous to CLK.
- mic_sck  out  1  I2S bit clock, shared by all mics.
- mic_ws  out  1  I2S word select: low = left slot, high = right slot.
- select  in  3  bank index from the DMA: 1..NUM_MICS.
- mic_data  out  32  sign-extended sample of mic `select`; 0 for any other select value.
- frame_ack  in  1  one-cycle pulse from the consumer: bank fully read.
- read_ready  out  1  bank holds an unread frame.
- overrun_count  out  16  frames dropped because the bank was unread; saturates at 16'hFFFF.

## Operation

- Two states: IDLE and RUN.
  - IDLE → RUN when enable = 1.
  - RUN → IDLE when enable = 0; takes effect on the next CLK edge.
- In IDLE:
  - mic_sck = 0 and mic_ws = 0.
  - Divider, bit counter and shift registers are cleared.
  - The bank, read_ready and overrun_count keep their values.
- Divider div_cnt counts 0..SCK_DIV-1. mic_sck toggles on the CLK edge where div_cnt = SCK_DIV-1.
- Bit counter bit_cnt counts 0..63 and advances on each SCK falling edge.
- mic_ws is registered:
  - it is 1 when bit_cnt is in 32..63;
  - it changes only on SCK falling edges.
- The first SCK rising edge after entering RUN has bit_cnt = 0 with ws = 0.
- Each mic_sd bit passes through a 2-flop synchroniser before use.
- Sampling happens in the CLK cycle where mic_sck goes 0→1, using the synchronised data.
  - bit_cnt = 0: I2S delay bit, ignored.
  - bit_cnt = 1..24: shifted in MSB first into a 24-bit register per mic.
  - Right slot (bit_cnt 32..63): ignored.
- Frame latch, on the SCK rising edge with bit_cnt = 24, after that edge's bit is shifted in:
  - if read_ready = 0, or frame_ack = 1 in the same cycle: copy all shift registers into the bank, sign-extended (bank[i] = {{8{s[23]}}, s}), and set read_ready = 1;
  - otherwise: drop the frame, leave the bank unchanged, and increment overrun_count (saturating).
- frame_ack:
  - clears read_ready when no latch happens in the same cycle;
  - is ignored when read_ready = 0.
- mic_data = bank[select-1] for select in 1..NUM_MICS, else 32'd0.
  - Purely combinational from the registered bank.
  - Changes only when select changes or a latch occurs.
- Dropping enable mid-frame discards the partial shift contents. No partial frame is ever latched.

## Timing

- Reset values:
  - mic_sck 0, mic_ws 0, read_ready 0, overrun_count 0.
  - All bank entries 0, so mic_data = 0.
  - State IDLE; all counters 0.
- Frame period is 128·SCK_DIV CLK cycles (1024 at default).
- Latency from mic_sd changing at pin to that bit being sampled: at most 3 CLK cycles. Requires SCK_DIV ≥ 4.
- read_ready rises on the CLK edge after the latch cycle.
- The bank is stable for the whole time read_ready = 1.
- The consumer has 128·SCK_DIV CLK cycles from read_ready rising to pulse frame_ack before the next frame overruns.
- RESET asserted mid-frame forces all outputs to reset values immediately (asynchronously).

## Structure

- Package mic_pkg holds:
  - NUM_MICS_DEF = 5, SAMPLE_W = 24, SLOT_BITS = 32, FRAME_BITS = 64;
  - the state enum typedef cap_state_t {IDLE, RUN};
  - typedef sample_t as logic [31:0].
- Sub-module i2s_clkgen: divider, mic_sck, mic_ws and bit counter.
  - Outputs: sck_rise and sck_fall strobes and bit_cnt.
  - Inputs: CLK, RESET, run.
- Top level holds: synchronisers, shift registers, bank, handshake and overrun logic.

## Test plan

- Reset, then enable = 1 → mic_sck period is 16 CLK; mic_ws high for 32 SCK, low for 32 SCK; first read_ready after 25 SCK rising edges (≈400 CLK).
- Mic k (k = 1..5) drives 24-bit value 24'h800001·k, truncated to 24 bits, MSB first from bit 1 of the left slot → each select = k returns that value sign-extended, e.g. mic 1 gives 32'hFF800001. select = 0 and select = 6 return 0.
- No frame_ack for 3 frames → bank keeps frame 1 values, read_ready stays 1, overrun_count = 2. Then frame_ack → read_ready = 0, and the next frame latches.
- frame_ack in the same cycle as the bit_cnt = 24 latch → read_ready stays 1, bank holds the new frame, overrun_count unchanged.
- enable dropped at bit_cnt = 12, raised again 100 CLK later → no latch of the partial frame; mic_sck/mic_ws idle at 0; the next full frame latches correct data.
- RESET pulsed mid-frame with read_ready = 1 → read_ready, overrun_count, mic_data, mic_sck and mic_ws all 0 immediately.
